local_injector: RTL and testbench
=================================

LOCAL_INJECTOR -- requirements
Module: local_injector

Interface
REQ-001 Parameter VC_NUM, default 2: number of virtual channels on the router local input port.
REQ-002 Parameter MAX_PKT_LEN, default 8: maximum payload words per packet; one body/tail flit per word.
REQ-003 Parameter LEN_W, default $clog2(MAX_PKT_LEN+1): width of the packet length field.
REQ-004 Port clk, input, 1: single clock; all state on rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port pkt_valid_i, input, 1: packet descriptor offered.
REQ-007 Port pkt_ready_o, output, 1: descriptor accepted this cycle when pkt_valid_i is also high.
REQ-008 Port dest_x_i / dest_y_i, input, noc_params coordinate widths: packet destination.
REQ-009 Port pkt_len_i, input, LEN_W: payload word count, legal range 1..MAX_PKT_LEN.
REQ-010 Port pld_valid_i / pld_ready_o / pld_data_i, input/output/input, 1/1/flit data width: payload word stream.
REQ-011 Port data_o, output, flit_t: flit to router local downstream port (data).
REQ-012 Port valid_flit_o, output, 1: data_o valid this cycle.
REQ-013 Port on_off_i, input, VC_NUM: per-VC credit-free on/off back-pressure from router.
REQ-014 Port is_allocatable_i, input, VC_NUM: per-VC "idle, may start new packet" from router.
REQ-015 Port err_o, output, 1: one-cycle pulse on illegal descriptor.

Function
REQ-016 FSM states IDLE, VC_SEL, SEND; reset state IDLE.
REQ-017 pkt_ready_o SHALL be 1 only in IDLE; handshake = pkt_valid_i & pkt_ready_o.
REQ-018 On handshake with pkt_len_i in 1..MAX_PKT_LEN: latch dest, length; go to VC_SEL.
REQ-019 On handshake with pkt_len_i = 0 or > MAX_PKT_LEN: descriptor dropped, err_o = 1 next cycle for exactly one cycle, remain IDLE.
REQ-020 VC_SEL: choose VC per REQ-033/034 among is_allocatable_i bits; latch vc; go to SEND same edge; if none set, stay in VC_SEL.
REQ-021 SEND, head pending: head flit (label HEAD, vc_id, dest_x, dest_y) issued when on_off_i[vc] = 1; no payload consumed.
REQ-022 SEND, head done: body/tail flit issued when on_off_i[vc] = 1 and pld_valid_i = 1; pld_ready_o = that same condition (no payload word consumed otherwise).
REQ-023 Remaining-word counter loaded with length, decremented per payload flit; last word labelled TAIL, others BODY; after tail issue go to IDLE.
REQ-024 data_o / valid_flit_o registered: flit appears one cycle after the issuing edge condition; valid_flit_o = 0 in any cycle with no issue.
REQ-025 Max rate one flit per cycle; a new descriptor accepted earliest the cycle after tail issue; min gap between packets 2 idle cycles (IDLE, VC_SEL).
REQ-026 on_off_i[vc] dropping mid-packet stalls without loss; resume on next cycle it is 1; other VCs' on_off_i ignored.
REQ-027 is_allocatable_i sampled only in VC_SEL; changes during SEND ignored.
REQ-028 pld_valid_i outside SEND-after-head ignored; pld_ready_o = 0 there.

Reset
REQ-029 rst asserted: state IDLE, counter 0, latched vc 0, rr pointer 0, valid_flit_o = 0, data_o = 0, err_o = 0, immediately (asynchronous).
REQ-030 pkt_ready_o = 0 while rst high; 1 in the first cycle after deassertion.
REQ-031 Reset mid-packet: partial packet abandoned, no tail emitted; router-side recovery is out of scope.
REQ-032 No output toggles on clk while rst is high.

Configuration
REQ-033 Macro INJ_RR_VC_EN defined: VC_SEL uses round-robin starting at pointer; pointer = chosen vc + 1 (mod VC_NUM) on selection.
REQ-034 INJ_RR_VC_EN undefined: VC_SEL picks lowest-index allocatable VC; no pointer register.

Verification
REQ-035 len=3, dest (2,1), all VCs allocatable/on: flits HEAD,BODY,BODY,TAIL on 4 consecutive cycles, vc 0, payload order preserved.
REQ-036 len=2, on_off_i[vc]=0 for 3 cycles after head: head, 3 idle cycles, BODY, TAIL; no duplicate, no loss.
REQ-037 pkt_len_i=0: err_o high exactly 1 cycle, valid_flit_o stays 0, pkt_ready_o stays 1.
REQ-038 is_allocatable_i=2'b00 for 5 cycles then 2'b10: FSM waits in VC_SEL, head issued on vc 1.
REQ-039 INJ_RR_VC_EN defined, three len=1 packets, is_allocatable_i=2'b11: vc sequence 0,1,0; undefined: 0,0,0.
REQ-040 rst pulse after 2nd flit of len=4 packet: valid_flit_o 0 immediately; next packet starts with HEAD.

Source files
------------

// File: rtl/local_injector.sv
// local_injector: turns packet descriptors plus a payload word stream into
// HEAD/BODY/TAIL flits for the router local input port.
// Each packet gets a virtual channel, and on/off back-pressure is honoured per VC.
// Optional feature: define INJ_RR_VC_EN to select the VC round-robin.
// By default the lowest-index allocatable VC is chosen.

package noc_params;
    localparam int DEST_ADDR_SIZE_X = 2;
    localparam int DEST_ADDR_SIZE_Y = 2;
    localparam int VC_SIZE          = 2;
    localparam int FLIT_DATA_SIZE   = 16;

    typedef enum logic [1:0] {
        HEAD = 2'd0,
        BODY = 2'd1,
        TAIL = 2'd2
    } flit_label_t;

    // Head flits carry the destination and have zero data.
    // Body/tail flits carry one payload word and have zero destination fields.
    typedef struct packed {
        flit_label_t                 label;
        logic [VC_SIZE-1:0]          vc_id;
        logic [DEST_ADDR_SIZE_X-1:0] dest_x;
        logic [DEST_ADDR_SIZE_Y-1:0] dest_y;
        logic [FLIT_DATA_SIZE-1:0]   data;
    } flit_t;
endpackage

module local_injector
    import noc_params::*;
#(
    parameter int VC_NUM      = 2,
    parameter int MAX_PKT_LEN = 8,
    parameter int LEN_W       = $clog2(MAX_PKT_LEN + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        pkt_valid_i,
    output logic                        pkt_ready_o,
    input  logic [DEST_ADDR_SIZE_X-1:0] dest_x_i,
    input  logic [DEST_ADDR_SIZE_Y-1:0] dest_y_i,
    input  logic [LEN_W-1:0]            pkt_len_i,
    input  logic                        pld_valid_i,
    output logic                        pld_ready_o,
    input  logic [FLIT_DATA_SIZE-1:0]   pld_data_i,
    output flit_t                       data_o,
    output logic                        valid_flit_o,
    input  logic [VC_NUM-1:0]           on_off_i,
    input  logic [VC_NUM-1:0]           is_allocatable_i,
    output logic                        err_o
);

    localparam int VC_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] VC_SEL = 2'd1;
    localparam logic [1:0] SEND   = 2'd2;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PKT_LEN);

    logic [1:0]                  state_q;
    logic [DEST_ADDR_SIZE_X-1:0] dest_x_q;
    logic [DEST_ADDR_SIZE_Y-1:0] dest_y_q;
    logic [LEN_W-1:0]            cnt_q;
    logic [VC_W-1:0]             vc_q;
    logic                        head_done_q;

    logic                        handshake;
    logic                        len_ok;
    logic                        head_issue;
    logic                        body_issue;
    logic                        is_tail;
    logic                        sel_found;
    logic [VC_W-1:0]             sel_vc;
    flit_t                       flit_d;

`ifdef INJ_RR_VC_EN
    logic [VC_W-1:0]             rr_ptr_q;
`endif

    // Handshake, issue conditions and payload back-pressure.
    // Reset gates pkt_ready_o directly, so it is low while rst is high.
    assign pkt_ready_o = (state_q == IDLE) && !rst;
    assign handshake   = pkt_valid_i && pkt_ready_o;
    assign len_ok      = (pkt_len_i != '0) && (pkt_len_i <= MAX_LEN);
    assign head_issue  = (state_q == SEND) && !head_done_q && on_off_i[vc_q];
    assign body_issue  = (state_q == SEND) && head_done_q && on_off_i[vc_q] && pld_valid_i;
    assign pld_ready_o = body_issue;
    assign is_tail     = (cnt_q == LEN_W'(1));

    // Choose a VC among the allocatable ones. The loop runs from high to low,
    // so the last hit written is the winner.
    always_comb begin
        // NOTE: every always_comb output gets a default first; otherwise a path
        // that skips the assignment infers a latch.
        sel_found = 1'b0;
        sel_vc    = '0;
`ifdef INJ_RR_VC_EN
        for (int i = VC_NUM - 1; i >= 0; i--) begin
            if (is_allocatable_i[(int'(rr_ptr_q) + i) % VC_NUM]) begin
                sel_found = 1'b1;
                sel_vc    = VC_W'((int'(rr_ptr_q) + i) % VC_NUM);
            end
        end
`else
        for (int i = VC_NUM - 1; i >= 0; i--) begin
            if (is_allocatable_i[i]) begin
                sel_found = 1'b1;
                sel_vc    = VC_W'(i);
            end
        end
`endif
    end

    // Build the flit that is registered when an issue condition holds.
    always_comb begin
        flit_d       = '0;
        flit_d.vc_id = VC_SIZE'(vc_q);
        if (head_issue) begin
            flit_d.label  = HEAD;
            flit_d.dest_x = dest_x_q;
            flit_d.dest_y = dest_y_q;
        end else begin
            flit_d.label = is_tail ? TAIL : BODY;
            flit_d.data  = pld_data_i;
        end
    end

    // Packet FSM: accept descriptor, pick VC, then stream head and payload.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: control state is reset so the FSM leaves reset in a known state.
        // Sequential state uses <= so every register samples pre-edge values.
        if (rst) begin
            state_q     <= IDLE;
            dest_x_q    <= '0;
            dest_y_q    <= '0;
            cnt_q       <= '0;
            vc_q        <= '0;
            head_done_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (handshake && len_ok) begin
                        dest_x_q <= dest_x_i;
                        dest_y_q <= dest_y_i;
                        cnt_q    <= pkt_len_i;
                        state_q  <= VC_SEL;
                    end
                end
                VC_SEL: begin
                    if (sel_found) begin
                        vc_q        <= sel_vc;
                        head_done_q <= 1'b0;
                        state_q     <= SEND;
                    end
                end
                SEND: begin
                    if (head_issue) begin
                        head_done_q <= 1'b1;
                    end
                    if (body_issue) begin
                        cnt_q <= cnt_q - LEN_W'(1);
                        if (is_tail) begin
                            head_done_q <= 1'b0;
                            state_q     <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Registered flit output and one-cycle error pulse.
    // data_o holds its last value when no flit is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_flit_o <= 1'b0;
            data_o       <= '0;
            err_o        <= 1'b0;
        end else begin
            valid_flit_o <= head_issue || body_issue;
            if (head_issue || body_issue) begin
                data_o <= flit_d;
            end
            err_o <= handshake && !len_ok;
        end
    end

`ifdef INJ_RR_VC_EN
    // Round-robin pointer moves to the VC after the one just chosen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else if (state_q == VC_SEL && sel_found) begin
            rr_ptr_q <= (int'(sel_vc) == VC_NUM - 1) ? '0 : sel_vc + VC_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_local_injector.sv
// Testbench for local_injector. Expected flits go into a scoreboard queue
// when each packet is set up. A monitor on the falling edge pops the queue
// and compares whenever valid_flit_o is high.
// The expected VC choice depends on whether INJ_RR_VC_EN is defined.

module tb_local_injector;
    import noc_params::*;

    localparam int VC_NUM      = 2;
    localparam int MAX_PKT_LEN = 8;
    localparam int LEN_W       = 4;

    logic                        clk;
    logic                        rst;
    logic                        pkt_valid_i;
    logic                        pkt_ready_o;
    logic [DEST_ADDR_SIZE_X-1:0] dest_x_i;
    logic [DEST_ADDR_SIZE_Y-1:0] dest_y_i;
    logic [LEN_W-1:0]            pkt_len_i;
    logic                        pld_valid_i;
    logic                        pld_ready_o;
    logic [FLIT_DATA_SIZE-1:0]   pld_data_i;
    flit_t                       data_o;
    logic                        valid_flit_o;
    logic [VC_NUM-1:0]           on_off_i;
    logic [VC_NUM-1:0]           is_allocatable_i;
    logic                        err_o;

    flit_t                       sb_q[$];
    int                          cyc_q[$];
    logic [FLIT_DATA_SIZE-1:0]   pld_q[$];

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int n_flits  = 0;
    int err_seen = 0;
    int tb_ptr   = 0;
    bit take;

    local_injector #(
        .VC_NUM      (VC_NUM),
        .MAX_PKT_LEN (MAX_PKT_LEN),
        .LEN_W       (LEN_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .pkt_valid_i      (pkt_valid_i),
        .pkt_ready_o      (pkt_ready_o),
        .dest_x_i         (dest_x_i),
        .dest_y_i         (dest_y_i),
        .pkt_len_i        (pkt_len_i),
        .pld_valid_i      (pld_valid_i),
        .pld_ready_o      (pld_ready_o),
        .pld_data_i       (pld_data_i),
        .data_o           (data_o),
        .valid_flit_o     (valid_flit_o),
        .on_off_i         (on_off_i),
        .is_allocatable_i (is_allocatable_i),
        .err_o            (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic flit_t mk_flit(input flit_label_t lbl, input int vc,
                                      input logic [1:0] dx, input logic [1:0] dy,
                                      input logic [15:0] d);
        flit_t f;
        f       = '0;
        f.label = lbl;
        f.vc_id = VC_SIZE'(vc);
        if (lbl == HEAD) begin
            f.dest_x = dx;
            f.dest_y = dy;
        end else begin
            f.data = d;
        end
        return f;
    endfunction

    // Reference VC choice for a given allocatable mask.
    function automatic int pick_vc(input logic [VC_NUM-1:0] alloc);
        int v;
        int idx;
        v = -1;
`ifdef INJ_RR_VC_EN
        for (int i = 0; i < VC_NUM; i++) begin
            idx = (tb_ptr + i) % VC_NUM;
            if (v < 0 && alloc[idx]) v = idx;
        end
        if (v >= 0) tb_ptr = (v + 1) % VC_NUM;
`else
        for (int i = 0; i < VC_NUM; i++) begin
            if (v < 0 && alloc[i]) v = i;
        end
`endif
        return v;
    endfunction

    // Queue the expected flits and the payload words of one packet.
    task automatic expect_pkt(input int vc, input logic [1:0] dx, input logic [1:0] dy,
                              input int len, input logic [15:0] base);
        flit_label_t lbl;
        sb_q.push_back(mk_flit(HEAD, vc, dx, dy, 16'h0));
        for (int i = 0; i < len; i++) begin
            lbl = (i == len - 1) ? TAIL : BODY;
            sb_q.push_back(mk_flit(lbl, vc, 2'd0, 2'd0, base + 16'(i)));
            pld_q.push_back(base + 16'(i));
        end
    endtask

    // Offer a descriptor. Returns 1 ns after the accepting edge.
    task automatic send_desc(input logic [1:0] dx, input logic [1:0] dy, input int len);
        bit accepted;
        accepted = 1'b0;
        @(posedge clk);
        #1;
        pkt_valid_i = 1'b1;
        dest_x_i    = dx;
        dest_y_i    = dy;
        pkt_len_i   = LEN_W'(len);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (pkt_ready_o) begin
                accepted = 1'b1;
                break;
            end
        end
        check("desc_accept", 64'(accepted), 64'd1);
        @(posedge clk);
        #1;
        pkt_valid_i = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (sb_q.size() == 0) break;
        end
        check("drain", 64'(sb_q.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: count error pulses and check every presented flit.
    always @(negedge clk) begin
        cyc++;
        if (err_o === 1'b1) err_seen++;
        if (valid_flit_o === 1'b1) begin
            n_flits++;
            cyc_q.push_back(cyc);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_flit: got %0h expected none", data_o);
            end else begin
                check("flit", 64'(data_o), 64'(sb_q.pop_front()));
            end
        end
    end

    // Payload source: offers the head of pld_q and pops it once it is consumed.
    initial begin
        pld_valid_i = 1'b0;
        pld_data_i  = '0;
        forever begin
            @(negedge clk);
            take = pld_valid_i && pld_ready_o;
            @(posedge clk);
            #2;
            if (take && pld_q.size() > 0) void'(pld_q.pop_front());
            pld_valid_i = (pld_q.size() > 0);
            pld_data_i  = (pld_q.size() > 0) ? pld_q[0] : '0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int vc;
        int n0;
        int vcs[3];

        rst              = 1'b1;
        pkt_valid_i      = 1'b0;
        dest_x_i         = '0;
        dest_y_i         = '0;
        pkt_len_i        = '0;
        on_off_i         = 2'b11;
        is_allocatable_i = 2'b11;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_valid", 64'(valid_flit_o), 64'd0);
        check("rst_data", 64'(data_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_pkt_ready", 64'(pkt_ready_o), 64'd0);
        check("rst_pld_ready", 64'(pld_ready_o), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_release_ready", 64'(pkt_ready_o), 64'd1);

        // len=3 to (2,1): four back-to-back flits.
        vc = pick_vc(2'b11);
        cyc_q.delete();
        expect_pkt(vc, 2'd2, 2'd1, 3, 16'hA000);
        send_desc(2'd2, 2'd1, 3);
        wait_drain(40);
        check("t1_nflits", 64'(cyc_q.size()), 64'd4);
        if (cyc_q.size() >= 4) begin
            for (int i = 1; i < 4; i++) check("t1_consecutive", 64'(cyc_q[i] - cyc_q[0]), 64'(i));
        end

        // Illegal lengths 0 and MAX+1: one error pulse each, no flits.
        err_seen = 0;
        n0 = n_flits;
        send_desc(2'd1, 2'd1, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check("t2_ready_stays", 64'(pkt_ready_o), 64'd1);
        end
        check("t2_err_once", 64'(err_seen), 64'd1);
        check("t2_no_flit", 64'(n_flits), 64'(n0));
        err_seen = 0;
        send_desc(2'd0, 2'd0, MAX_PKT_LEN + 1);
        repeat (3) @(negedge clk);
        #1;
        check("t2_err_over", 64'(err_seen), 64'd1);
        check("t2_no_flit_over", 64'(n_flits), 64'(n0));

        // Maximum legal length.
        err_seen = 0;
        vc = pick_vc(2'b11);
        expect_pkt(vc, 2'd3, 2'd3, MAX_PKT_LEN, 16'hB000);
        send_desc(2'd3, 2'd3, MAX_PKT_LEN);
        wait_drain(60);
        check("t2_max_no_err", 64'(err_seen), 64'd0);

        // len=2 with the packet's VC turned off for 3 cycles after the head.
        vc = pick_vc(2'b11);
        cyc_q.delete();
        expect_pkt(vc, 2'd0, 2'd2, 2, 16'hC000);
        send_desc(2'd0, 2'd2, 2);
        @(posedge clk);
        @(posedge clk);
        #1;
        on_off_i = 2'b11 ^ (2'b01 << vc);
        repeat (3) @(posedge clk);
        #1;
        on_off_i = 2'b11;
        wait_drain(40);
        check("t3_nflits", 64'(cyc_q.size()), 64'd3);
        if (cyc_q.size() >= 3) begin
            check("t3_body_gap", 64'(cyc_q[1] - cyc_q[0]), 64'd4);
            check("t3_tail_gap", 64'(cyc_q[2] - cyc_q[0]), 64'd5);
        end

        // No VC allocatable for 5 cycles, then only VC 1.
        is_allocatable_i = 2'b00;
        vc = pick_vc(2'b10);
        expect_pkt(vc, 2'd3, 2'd0, 1, 16'hF000);
        send_desc(2'd3, 2'd0, 1);
        n0 = n_flits;
        repeat (5) @(posedge clk);
        #1;
        check("t4_waits_no_flit", 64'(n_flits), 64'(n0));
        check("t4_waits_not_ready", 64'(pkt_ready_o), 64'd0);
        is_allocatable_i = 2'b10;
        wait_drain(40);
        is_allocatable_i = 2'b11;

        // Reset pulse after the second flit of a len=4 packet.
        vc = pick_vc(2'b11);
        n0 = n_flits;
        expect_pkt(vc, 2'd1, 2'd2, 4, 16'hD000);
        send_desc(2'd1, 2'd2, 4);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (n_flits >= n0 + 2) break;
        end
        check("t5_two_flits", 64'(n_flits - n0), 64'd2);
        rst = 1'b1;
        #1;
        check("t5_valid_async", 64'(valid_flit_o), 64'd0);
        check("t5_data_async", 64'(data_o), 64'd0);
        check("t5_ready_in_rst", 64'(pkt_ready_o), 64'd0);
        check("t5_pld_ready_in_rst", 64'(pld_ready_o), 64'd0);
        sb_q.delete();
        pld_q.delete();
        tb_ptr = 0;
        @(posedge clk);
        #1;
        check("t5_valid_held", 64'(valid_flit_o), 64'd0);
        check("t5_err_held", 64'(err_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t5_ready_after", 64'(pkt_ready_o), 64'd1);

        // Three len=1 packets from reset: VC sequence depends on the selection mode.
`ifdef INJ_RR_VC_EN
        vcs = '{0, 1, 0};
`else
        vcs = '{0, 0, 0};
`endif
        for (int k = 0; k < 3; k++) begin
            expect_pkt(vcs[k], 2'(k), 2'd1, 1, 16'hE000 + 16'(k));
            send_desc(2'(k), 2'd1, 1);
            wait_drain(40);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
